// File: rtl/uart_frame_parser_if.sv
// Byte-stream in / register-write and ack out bundle for uart_frame_parser.
// The parser sits on the slave side; whoever feeds it bytes is the master.
interface uart_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ack_req;
  logic [7:0]  ack_data;
  logic        frame_err;
  logic [7:0]  err_cnt;

  modport master (
    output rx_data, rx_vld,
    input  wr_en, wr_addr, wr_data, ack_req, ack_data, frame_err, err_cnt
  );

  modport slave (
    input  rx_data, rx_vld,
    output wr_en, wr_addr, wr_data, ack_req, ack_data, frame_err, err_cnt
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SOF/ADDR/DATA_H/DATA_L/CHK frames from a UART byte stream and turns
// each good frame into a single register write plus an ACK byte. Bad checksums
// produce a NAK and an error pulse; a stalled frame is dropped after
// TIMEOUT_CYC idle cycles with an error pulse but no response byte.
module uart_frame_parser #(
  parameter int          TIMEOUT_CYC = 520833,
  parameter logic [7:0]  SOF_BYTE    = 8'h55
) (
  input  logic          clk,
  input  logic          rst,
  uart_frame_parser_if.slave bus
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       ACK_BYTE = 8'h06;
  localparam logic [7:0]       NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DH,
    GET_DL,
    GET_CHK
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       dh_reg, dh_next;
  logic [7:0]       dl_reg, dl_next;
  logic [7:0]       xor_reg, xor_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wr_en_reg, wr_en_next;
  logic [7:0]       wr_addr_reg, wr_addr_next;
  logic [15:0]      wr_data_reg, wr_data_next;
  logic             ack_req_reg, ack_req_next;
  logic [7:0]       ack_data_reg, ack_data_next;
  logic             frame_err_reg, frame_err_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;
  logic [7:0]       err_cnt_inc;
  logic             timeout;

  // Saturating increment shared by the checksum-error and timeout paths.
  assign err_cnt_inc = (err_cnt_reg == 8'hFF) ? err_cnt_reg : err_cnt_reg + 8'd1;

  // Expiry only counts when no byte arrives in the same cycle: the byte wins.
  assign timeout = (state_reg != IDLE) && !bus.rx_vld && (cnt_reg == CNT_LAST);

  // State and output registers; reset abandons any frame in progress silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= 8'h00;
      dh_reg        <= 8'h00;
      dl_reg        <= 8'h00;
      xor_reg       <= 8'h00;
      cnt_reg       <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= 8'h00;
      wr_data_reg   <= 16'h0000;
      ack_req_reg   <= 1'b0;
      ack_data_reg  <= 8'h00;
      frame_err_reg <= 1'b0;
      err_cnt_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      dh_reg        <= dh_next;
      dl_reg        <= dl_next;
      xor_reg       <= xor_next;
      cnt_reg       <= cnt_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      ack_req_reg   <= ack_req_next;
      ack_data_reg  <= ack_data_next;
      frame_err_reg <= frame_err_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  // Next-state, byte capture, timeout and strobe generation.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    dh_next        = dh_reg;
    dl_next        = dl_reg;
    xor_next       = xor_reg;
    cnt_next       = cnt_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    ack_req_next   = 1'b0;
    ack_data_next  = ack_data_reg;
    frame_err_next = 1'b0;
    err_cnt_next   = err_cnt_reg;

    // Idle-gap counter: parked at 0 in IDLE, restarted by every byte.
    if (state_reg == IDLE || bus.rx_vld || timeout) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    if (bus.rx_vld) begin
      unique case (state_reg)
        IDLE: begin
          // Anything other than the marker is line noise and is dropped.
          if (bus.rx_data == SOF_BYTE) begin
            xor_next   = 8'h00;
            state_next = GET_ADDR;
          end
        end
        GET_ADDR: begin
          addr_next  = bus.rx_data;
          xor_next   = bus.rx_data;
          state_next = GET_DH;
        end
        GET_DH: begin
          dh_next    = bus.rx_data;
          xor_next   = xor_reg ^ bus.rx_data;
          state_next = GET_DL;
        end
        GET_DL: begin
          dl_next    = bus.rx_data;
          xor_next   = xor_reg ^ bus.rx_data;
          state_next = GET_CHK;
        end
        GET_CHK: begin
          ack_req_next = 1'b1;
          if (bus.rx_data == xor_reg) begin
            wr_en_next    = 1'b1;
            wr_addr_next  = addr_reg;
            wr_data_next  = {dh_reg, dl_reg};
            ack_data_next = ACK_BYTE;
          end else begin
            frame_err_next = 1'b1;
            ack_data_next  = NAK_BYTE;
            err_cnt_next   = err_cnt_inc;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      frame_err_next = 1'b1;
      err_cnt_next   = err_cnt_inc;
      state_next     = IDLE;
    end
  end

  // Registered outputs onto the bus.
  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.ack_req   = ack_req_reg;
  assign bus.ack_data  = ack_data_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.err_cnt   = err_cnt_reg;

endmodule
